multicycle_controller: RTL and testbench



---
 rtl/multicycle_controller_pkg.sv | 52 +++++
 rtl/multicycle_controller.sv | 177 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared encodings for the multi-cycle RV32I control FSM
package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_UTYPE    = 4'd8,
      S_ALUWB    = 4'd9,
      S_BRANCH   = 4'd10,
      S_JAL      = 4'd11,
      S_JALR     = 4'd12,
      S_JALRPC   = 4'd13,
      S_TRAP     = 4'd15
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_UTYPE = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE = 2'b11;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_RDATA     = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM of the multi-cycle RV32I core
module multicycle_controller
   import multicycle_controller_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       force_sub,
   output logic       illegal_instr,
   output logic       instr_retired,
   output logic [3:0] state_o
);

   state_e r_state;
   state_e w_next;
   logic   w_br_valid;
   logic   w_br_take;
   logic   w_mem_req;
   logic   w_mem_write;
   logic   w_ir_write;
   logic   w_pc_write;
   logic   w_reg_write;
   logic   w_retired;

   assign w_br_valid = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
   assign w_br_take  = (funct3 == F3_BEQ) ? zero :
                       (funct3 == F3_BNE) ? ~zero : 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:    if (mem_ready) w_next = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: w_next = S_MEMADR;
               OP_RTYPE:          w_next = S_EXECR;
               OP_ITYPE:          w_next = S_EXECI;
               OP_BRANCH:         w_next = S_BRANCH;
               OP_JAL:            w_next = S_JAL;
               OP_JALR:           w_next = S_JALR;
               OP_LUI, OP_AUIPC:  w_next = S_UTYPE;
               default:           w_next = S_TRAP;
            endcase
         end
         S_MEMADR:   w_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
         S_MEMWB:    w_next = S_FETCH;
         S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
         S_EXECR:    w_next = S_ALUWB;
         S_EXECI:    w_next = S_ALUWB;
         S_UTYPE:    w_next = S_ALUWB;
         S_ALUWB:    w_next = S_FETCH;
         S_BRANCH:   w_next = w_br_valid ? S_FETCH : S_TRAP;
         S_JAL:      w_next = S_ALUWB;
         S_JALR:     w_next = S_JALRPC;
         S_JALRPC:   w_next = S_ALUWB;
         S_TRAP:     w_next = S_TRAP;
         default:    w_next = S_TRAP;
      endcase
   end

   always_comb begin
      w_mem_req   = 1'b0;
      w_mem_write = 1'b0;
      w_ir_write  = 1'b0;
      w_pc_write  = 1'b0;
      w_reg_write = 1'b0;
      w_retired   = 1'b0;
      adr_src     = 1'b0;
      result_src  = RES_ALUOUT;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RS2;
      alu_op      = ALUOP_ADD;
      force_sub   = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_req  = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            w_ir_write = mem_ready;
            w_pc_write = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMREAD: begin
            w_mem_req = 1'b1;
            adr_src   = 1'b1;
         end
         S_MEMWB: begin
            result_src  = RES_RDATA;
            w_reg_write = 1'b1;
            w_retired   = 1'b1;
         end
         S_MEMWRITE: begin
            w_mem_req   = 1'b1;
            adr_src     = 1'b1;
            w_mem_write = mem_ready;
            w_retired   = mem_ready;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_RTYPE;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_ITYPE;
         end
         S_UTYPE: begin
            alu_src_a = (op == OP_AUIPC) ? SRCA_OLDPC : SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_UTYPE;
         end
         S_ALUWB: begin
            w_reg_write = 1'b1;
            w_retired   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a  = SRCA_RS1;
            alu_op     = ALUOP_RTYPE;
            force_sub  = 1'b1;
            w_pc_write = w_br_take;
            w_retired  = w_br_valid;
         end
         S_JAL: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            w_pc_write = 1'b1;
         end
         S_JALR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
         end
         S_JALRPC: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            w_pc_write = 1'b1;
         end
         default: ;
      endcase
   end

   // Reset must suppress every side effect even though selects keep their FETCH values.
   assign mem_req       = w_mem_req   & ~rst;
   assign mem_write     = w_mem_write & ~rst;
   assign ir_write      = w_ir_write  & ~rst;
   assign pc_write      = w_pc_write  & ~rst;
   assign reg_write     = w_reg_write & ~rst;
   assign instr_retired = w_retired   & ~rst;
   assign illegal_instr = (r_state == S_TRAP);
   assign state_o       = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;
   import multicycle_controller_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
   logic       force_sub, illegal_instr, instr_retired;
   logic [3:0] state_o;

   typedef struct packed {
      logic [3:0] st;
      logic       mreq, mwr, adr, irw, pcw, rgw;
      logic [1:0] rs, sa, sb, aop;
      logic       fsub, ill, ret;
   } vec_t;

   vec_t       w_obs;
   vec_t       q[$];
   logic       rdy_q[$];
   int         n_vec = 0;
   int         n_err = 0;
   int         cur_id = 0;
   logic [6:0] ops [10];

   multicycle_controller dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
      .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .force_sub(force_sub),
      .illegal_instr(illegal_instr), .instr_retired(instr_retired), .state_o(state_o)
   );

   always #5 clk = ~clk;

   assign w_obs = {state_o, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                   result_src, alu_src_a, alu_src_b, alu_op, force_sub, illegal_instr, instr_retired};

   function automatic vec_t mk(state_e s);
      vec_t v = '0;
      v.st = s;
      return v;
   endfunction

   function automatic vec_t fetch_v(logic rdy);
      vec_t v = mk(S_FETCH);
      v.mreq = 1'b1; v.sb = SRCB_FOUR; v.rs = RES_ALURESULT;
      v.irw = rdy; v.pcw = rdy;
      return v;
   endfunction

   function automatic vec_t trap_v();
      vec_t v = mk(S_TRAP);
      v.ill = 1'b1;
      return v;
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic check(input vec_t e, input string tag);
      n_vec++;
      assert (w_obs === e) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, w_obs, e);
      end
   endtask

   task automatic push(input vec_t v, input logic r);
      q.push_back(v);
      rdy_q.push_back(r);
   endtask

   task automatic push_aluwb();
      vec_t v = mk(S_ALUWB);
      v.rgw = 1'b1; v.ret = 1'b1;
      push(v, rnd());
   endtask

   // Expected per-cycle outputs for one instruction, from fetch to retirement or trap.
   task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic z,
                        input int fw, input int mw, output bit trapped);
      vec_t v;
      trapped = 1'b0;
      for (int i = 0; i < fw; i++) push(fetch_v(1'b0), 1'b0);
      push(fetch_v(1'b1), 1'b1);
      v = mk(S_DECODE); v.sa = SRCA_OLDPC; v.sb = SRCB_IMM;
      push(v, rnd());
      case (o)
         OP_LOAD, OP_STORE: begin
            v = mk(S_MEMADR); v.sa = SRCA_RS1; v.sb = SRCB_IMM;
            push(v, rnd());
            v = mk((o == OP_LOAD) ? S_MEMREAD : S_MEMWRITE); v.mreq = 1'b1; v.adr = 1'b1;
            for (int i = 0; i < mw; i++) push(v, 1'b0);
            if (o == OP_STORE) begin
               v.mwr = 1'b1; v.ret = 1'b1;
            end
            push(v, 1'b1);
            if (o == OP_LOAD) begin
               v = mk(S_MEMWB); v.rs = RES_RDATA; v.rgw = 1'b1; v.ret = 1'b1;
               push(v, rnd());
            end
         end
         OP_RTYPE: begin
            v = mk(S_EXECR); v.sa = SRCA_RS1; v.aop = ALUOP_RTYPE;
            push(v, rnd()); push_aluwb();
         end
         OP_ITYPE: begin
            v = mk(S_EXECI); v.sa = SRCA_RS1; v.sb = SRCB_IMM; v.aop = ALUOP_ITYPE;
            push(v, rnd()); push_aluwb();
         end
         OP_LUI, OP_AUIPC: begin
            v = mk(S_UTYPE); v.sb = SRCB_IMM; v.aop = ALUOP_UTYPE;
            v.sa = (o == OP_AUIPC) ? SRCA_OLDPC : SRCA_RS1;
            push(v, rnd()); push_aluwb();
         end
         OP_JAL: begin
            v = mk(S_JAL); v.sa = SRCA_OLDPC; v.sb = SRCB_FOUR; v.pcw = 1'b1;
            push(v, rnd()); push_aluwb();
         end
         OP_JALR: begin
            v = mk(S_JALR); v.sa = SRCA_RS1; v.sb = SRCB_IMM;
            push(v, rnd());
            v = mk(S_JALRPC); v.sa = SRCA_OLDPC; v.sb = SRCB_FOUR; v.pcw = 1'b1;
            push(v, rnd()); push_aluwb();
         end
         OP_BRANCH: begin
            v = mk(S_BRANCH); v.sa = SRCA_RS1; v.sb = SRCB_RS2; v.aop = ALUOP_RTYPE; v.fsub = 1'b1;
            if (f3 == 3'd0) v.pcw = z;
            else if (f3 == 3'd1) v.pcw = ~z;
            v.ret = (f3 <= 3'd1);
            push(v, rnd());
            if (f3 > 3'd1) begin
               push(trap_v(), rnd());
               trapped = 1'b1;
            end
         end
         default: begin
            push(trap_v(), rnd());
            trapped = 1'b1;
         end
      endcase
   endtask

   task automatic run(input int lim);
      int k = 0;
      while (q.size() > 0 && k < lim) begin
         vec_t e = q.pop_front();
         mem_ready = rdy_q.pop_front();
         #1;
         check(e, $sformatf("instr%0d_step%0d", cur_id, k));
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   task automatic do_reset();
      vec_t v = fetch_v(1'b0);
      v.mreq = 1'b0;
      rst = 1'b1;
      mem_ready = 1'b1;
      #1;
      check(v, "reset_async");
      @(posedge clk);
      #1;
      check(v, "reset_held");
      rst = 1'b0;
   endtask

   task automatic trap_hold(input int n);
      for (int i = 0; i < n; i++) begin
         mem_ready = rnd();
         #1;
         check(trap_v(), $sformatf("trap_hold%0d", i));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic z,
                        input int fw, input int mw, input int hold);
      bit trapped;
      cur_id++;
      op = o; funct3 = f3; zero = z;
      build(o, f3, z, fw, mw, trapped);
      run(1000);
      if (trapped) begin
         trap_hold(hold);
         do_reset();
      end
   endtask

   initial begin
      vec_t rv;
      bit   tr;
      ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_JALR,
              OP_LUI, OP_AUIPC, 7'b1111111};
      rst = 1'b1; op = OP_RTYPE; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // load stalled in MEMREAD, then reset asynchronously mid-cycle
      cur_id++;
      op = OP_LOAD;
      build(OP_LOAD, 3'd2, 1'b0, 0, 5, tr);
      run(4);
      q.delete();
      rdy_q.delete();
      mem_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      rv = fetch_v(1'b0); rv.mreq = 1'b0;
      check(rv, "reset_mid_memread");
      mem_ready = 1'b1;
      #1;
      check(rv, "reset_mid_memread_rdy");
      @(posedge clk);
      #1;
      rst = 1'b0;

      instr(OP_RTYPE, 3'd0, 1'b0, 1, 0, 0);
      instr(OP_RTYPE, 3'd0, 1'b0, 0, 0, 0);
      instr(OP_LOAD, 3'd2, 1'b0, 2, 2, 0);
      instr(OP_STORE, 3'd2, 1'b0, 0, 1, 0);
      instr(OP_BRANCH, 3'd0, 1'b1, 0, 0, 0);
      instr(OP_BRANCH, 3'd0, 1'b0, 0, 0, 0);
      instr(OP_BRANCH, 3'd1, 1'b1, 0, 0, 0);
      instr(OP_BRANCH, 3'd1, 1'b0, 0, 0, 0);
      instr(OP_BRANCH, 3'd4, 1'b1, 0, 0, 3);
      instr(OP_JALR, 3'd0, 1'b0, 0, 0, 0);
      instr(OP_JAL, 3'd0, 1'b0, 0, 0, 0);
      instr(OP_LUI, 3'd0, 1'b0, 0, 0, 0);
      instr(OP_AUIPC, 3'd0, 1'b0, 0, 0, 0);
      instr(OP_ITYPE, 3'd0, 1'b0, 0, 0, 0);
      instr(7'b1111111, 3'd0, 1'b0, 0, 0, 20);

      for (int n = 0; n < 150; n++) begin
         logic [6:0] o;
         logic [2:0] f3;
         o = ($urandom_range(0, 19) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
         if (o == OP_BRANCH && $urandom_range(0, 5) != 0) f3 = 3'($urandom_range(0, 1));
         else f3 = 3'($urandom_range(0, 7));
         instr(o, f3, rnd(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
